fp16_accumulator: RTL and testbench

Sequential half-precision (IEEE 754 binary16) accumulator that takes a stream of operands over a valid/ready handshake, folds each into a running sum through one combinational `fp_adder_subtractor` instance, and returns the final sum with sticky and result status flags. It sits directly upstream of the adder, sequencing and registering its operands, and directly downstream of it, capturing its result and flag outputs. It is the FP reduction path of the ALU.

---
 rtl/fp16_pkg.sv | 48 ++++
 rtl/fp_adder_subtractor.sv | 138 +++++++++++++
 rtl/fp16_accumulator.sv | 153 +++++++++++++++
 tb/tb_fp16_accumulator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared constants, FSM state type and fp16 classification helpers for the
// half-precision reduction path.
package fp16_pkg;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
    localparam logic [15:0] FP16_QNAN     = 16'h7FFF;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        ADD    = 2'd1,
        DONE   = 2'd2
    } acc_state_e;

    localparam int FLAG_NEG  = 4;
    localparam int FLAG_ZERO = 3;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_NAN  = 1;
    localparam int FLAG_SUB  = 0;

    // Flag vector of +0: only the zero bit is set.
    localparam logic [4:0] FLAGS_RESET = 5'b01000;

    // Returns {negative, zero, inf, nan, subnormal} for an fp16 value.
    function automatic logic [4:0] fp16_class(input logic [15:0] v);
        logic [4:0] f;
        f           = 5'b00000;
        f[FLAG_NEG]  = v[15];
        f[FLAG_ZERO] = (v[14:0] == 15'h0000);
        f[FLAG_INF]  = (v[14:10] == 5'h1F) && (v[9:0] == 10'h000);
        f[FLAG_NAN]  = (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
        f[FLAG_SUB]  = (v[14:10] == 5'h00) && (v[9:0] != 10'h000);
        return f;
    endfunction

    // Leading-zero count of a 14-bit mantissa; 14 when the input is zero.
    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] n;
        n = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (v[i]) begin
                n = 4'(13 - i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_adder_subtractor.sv
// Combinational fp16 adder/subtractor with round-to-nearest-even, gradual
// underflow, IEEE special-case handling and result classification flags.
module fp_adder_subtractor
    import fp16_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        add_sub,
    output logic [15:0] r,
    output logic        overflow,
    output logic        negative,
    output logic        zero,
    output logic        inf,
    output logic        nan,
    output logic        subnormal
);

    logic        sx_s, sy_s;
    logic [4:0]  ex_s, ey_s;
    logic [9:0]  fx_s, fy_s;
    logic        b_s_s, l_s_s, same_s;
    logic [4:0]  b_e_s, l_e_s, diff_s;
    logic [13:0] b_m_s, l_m_s, al_s;
    logic [27:0] al_full_s;
    logic [14:0] sum_s;
    logic [13:0] norm_s;
    logic [3:0]  lz_s;
    logic [5:0]  exp0_s, maxsh_s, sh_s, exp_n_s, exp_r_s;
    logic [11:0] mant_r_s;
    logic [9:0]  frac_s;
    logic        hid_s, inc_s;
    logic [4:0]  cls_s;

    assign sx_s = x[15];
    assign ex_s = x[14:10];
    assign fx_s = x[9:0];
    assign sy_s = y[15] ^ add_sub;
    assign ey_s = y[14:10];
    assign fy_s = y[9:0];

    // Align, add/subtract magnitudes, normalise, round and resolve specials.
    always_comb begin
        overflow = 1'b0;
        if ({ex_s, fx_s} >= {ey_s, fy_s}) begin
            b_s_s = sx_s; b_e_s = ex_s; b_m_s = {(ex_s != 5'd0), fx_s, 3'b000};
            l_s_s = sy_s; l_e_s = ey_s; l_m_s = {(ey_s != 5'd0), fy_s, 3'b000};
        end else begin
            b_s_s = sy_s; b_e_s = ey_s; b_m_s = {(ey_s != 5'd0), fy_s, 3'b000};
            l_s_s = sx_s; l_e_s = ex_s; l_m_s = {(ex_s != 5'd0), fx_s, 3'b000};
        end
        if (b_e_s == 5'd0) begin
            b_e_s = 5'd1;
        end else begin
            b_e_s = b_e_s;
        end
        if (l_e_s == 5'd0) begin
            l_e_s = 5'd1;
        end else begin
            l_e_s = l_e_s;
        end
        diff_s    = b_e_s - l_e_s;
        al_full_s = {l_m_s, 14'd0} >> diff_s;
        al_s      = al_full_s[27:14];
        if (diff_s >= 5'd28) begin
            al_s[0] = al_s[0] | (|l_m_s);
        end else begin
            al_s[0] = al_s[0] | (|al_full_s[13:0]);
        end
        same_s = (b_s_s == l_s_s);
        if (same_s) begin
            sum_s = {1'b0, b_m_s} + {1'b0, al_s};
        end else begin
            sum_s = {1'b0, b_m_s} - {1'b0, al_s};
        end

        exp0_s  = {1'b0, b_e_s};
        lz_s    = lzc14(sum_s[13:0]);
        maxsh_s = exp0_s - 6'd1;
        sh_s    = 6'd0;
        if (sum_s[14]) begin
            norm_s  = {sum_s[14:2], sum_s[1] | sum_s[0]};
            exp_n_s = exp0_s + 6'd1;
        end else begin
            // Stop shifting at the minimum exponent so tiny results stay subnormal.
            if ({2'b00, lz_s} > maxsh_s) begin
                sh_s = maxsh_s;
            end else begin
                sh_s = {2'b00, lz_s};
            end
            norm_s  = sum_s[13:0] << sh_s;
            exp_n_s = exp0_s - sh_s;
        end

        inc_s    = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_r_s = {1'b0, norm_s[13:3]} + {11'd0, inc_s};
        if (mant_r_s[11]) begin
            exp_r_s = exp_n_s + 6'd1;
            frac_s  = mant_r_s[10:1];
            hid_s   = 1'b1;
        end else begin
            exp_r_s = exp_n_s;
            frac_s  = mant_r_s[9:0];
            hid_s   = mant_r_s[10];
        end

        if (((ex_s == 5'h1F) && (fx_s != 10'd0)) || ((ey_s == 5'h1F) && (fy_s != 10'd0))) begin
            r = FP16_QNAN;
        end else if ((ex_s == 5'h1F) && (ey_s == 5'h1F)) begin
            if (sx_s == sy_s) begin
                r = {sx_s, FP16_POS_INF[14:0]};
            end else begin
                r = FP16_QNAN;
            end
        end else if (ex_s == 5'h1F) begin
            r = {sx_s, FP16_POS_INF[14:0]};
        end else if (ey_s == 5'h1F) begin
            r = {sy_s, FP16_POS_INF[14:0]};
        end else if (sum_s == 15'd0) begin
            // Exact cancellation gives +0; -0 survives only from -0 + -0.
            r = {(same_s ? b_s_s : 1'b0), 15'h0000};
        end else if (hid_s && (exp_r_s >= 6'd31)) begin
            r        = {b_s_s, FP16_POS_INF[14:0]};
            overflow = 1'b1;
        end else if (hid_s) begin
            r = {b_s_s, exp_r_s[4:0], frac_s};
        end else begin
            r = {b_s_s, 5'd0, frac_s};
        end
    end

    assign cls_s     = fp16_class(r);
    assign negative  = cls_s[FLAG_NEG];
    assign zero      = cls_s[FLAG_ZERO];
    assign inf       = cls_s[FLAG_INF];
    assign nan       = cls_s[FLAG_NAN];
    assign subnormal = cls_s[FLAG_SUB];

endmodule

// File: rtl/fp16_accumulator.sv
// Sequential fp16 accumulator: registers one operand at a time, folds it into
// the running sum through a single adder, and hands back the sum with status.
module fp16_accumulator
    import fp16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [4:0]       out_flags,
    output logic             out_ovf,
    output logic             out_nan_seen,
    output logic [CNT_W-1:0] out_count,
    output logic             out_count_sat
);

    acc_state_e        state_r, state_nxt_s;
    logic [15:0]       acc_r, op_q_r;
    logic              sub_q_r, last_q_r;
    logic [4:0]        flags_r;
    logic              ovf_r, nan_seen_r, sat_r;
    logic [CNT_W-1:0]  cnt_r, cnt_inc_s;
    logic              in_ready_r, out_valid_r;

    logic [15:0]       sum_s;
    logic              add_ovf_s, add_neg_s, add_zero_s, add_inf_s, add_nan_s, add_sub_s;

    fp_adder_subtractor u_adder (
        .x         (acc_r),
        .y         (op_q_r),
        .add_sub   (sub_q_r),
        .r         (sum_s),
        .overflow  (add_ovf_s),
        .negative  (add_neg_s),
        .zero      (add_zero_s),
        .inf       (add_inf_s),
        .nan       (add_nan_s),
        .subnormal (add_sub_s)
    );

    // Next-state decode; clear overrides any handshake in flight.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = ACCEPT;
        end else begin
            case (state_r)
                ACCEPT: state_nxt_s = in_valid ? ADD : ACCEPT;
                ADD:    state_nxt_s = last_q_r ? DONE : ACCEPT;
                DONE:   state_nxt_s = out_ready ? ACCEPT : DONE;
                default: state_nxt_s = ACCEPT;
            endcase
        end
    end

    // Saturating operand count.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end
    end

    // State and handshake flops; ready/valid are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ACCEPT;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ACCEPT);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

    // Datapath: operand capture, accumulation, status and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= FP16_POS_ZERO;
            op_q_r     <= FP16_POS_ZERO;
            sub_q_r    <= 1'b0;
            last_q_r   <= 1'b0;
            flags_r    <= FLAGS_RESET;
            ovf_r      <= 1'b0;
            nan_seen_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
        end else if (clear) begin
            acc_r      <= FP16_POS_ZERO;
            op_q_r     <= FP16_POS_ZERO;
            sub_q_r    <= 1'b0;
            last_q_r   <= 1'b0;
            flags_r    <= FLAGS_RESET;
            ovf_r      <= 1'b0;
            nan_seen_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
        end else begin
            case (state_r)
                ACCEPT: begin
                    if (in_valid) begin
                        op_q_r   <= in_data;
                        sub_q_r  <= in_sub;
                        last_q_r <= in_last;
                    end
                end
                ADD: begin
                    acc_r      <= sum_s;
                    ovf_r      <= ovf_r | add_ovf_s;
                    nan_seen_r <= nan_seen_r | add_nan_s;
                    flags_r    <= {add_neg_s, add_zero_s, add_inf_s, add_nan_s, add_sub_s};
                    cnt_r      <= cnt_inc_s;
                    sat_r      <= (cnt_inc_s == {CNT_W{1'b1}});
                end
                DONE: begin
                    if (out_ready) begin
                        acc_r      <= FP16_POS_ZERO;
                        flags_r    <= FLAGS_RESET;
                        ovf_r      <= 1'b0;
                        nan_seen_r <= 1'b0;
                        cnt_r      <= {CNT_W{1'b0}};
                        sat_r      <= 1'b0;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign out_data      = acc_r;
    assign out_flags     = flags_r;
    assign out_ovf       = ovf_r;
    assign out_nan_seen  = nan_seen_r;
    assign out_count     = cnt_r;
    assign out_count_sat = sat_r;

endmodule

// File: tb/tb_fp16_accumulator.sv
// Scoreboard bench for fp16_accumulator: a default-width instance and a
// 2-bit-counter instance for the saturation case.
module tb_fp16_accumulator;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  flags;
        logic        ovf;
        logic        nan;
        logic [7:0]  count;
        logic        sat;
    } res_t;

    localparam res_t RST_RES = '{data: 16'h0000, flags: 5'b01000, ovf: 1'b0, nan: 1'b0, count: 8'd0, sat: 1'b0};

    logic        clk = 1'b0;
    logic        rst_n, clear;
    logic        in_valid, in_ready, in_sub, in_last, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic [4:0]  out_flags;
    logic        out_ovf, out_nan_seen, out_count_sat;
    logic [7:0]  out_count;
    logic        in_valid2, in_ready2, in_sub2, in_last2, out_valid2, out_ready2;
    logic [15:0] in_data2, out_data2;
    logic [4:0]  out_flags2;
    logic        out_ovf2, out_nan_seen2, out_count_sat2;
    logic [1:0]  out_count2;

    int   total = 0;
    int   bad = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    fp16_accumulator dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
        .out_ovf(out_ovf), .out_nan_seen(out_nan_seen), .out_count(out_count), .out_count_sat(out_count_sat)
    );

    fp16_accumulator #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_sub(in_sub2), .in_last(in_last2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_flags(out_flags2),
        .out_ovf(out_ovf2), .out_nan_seen(out_nan_seen2), .out_count(out_count2), .out_count_sat(out_count_sat2)
    );

    function automatic res_t snap(input int which);
        res_t v;
        if (which == 0) begin
            v = '{data: out_data, flags: out_flags, ovf: out_ovf, nan: out_nan_seen, count: out_count, sat: out_count_sat};
        end else begin
            v = '{data: out_data2, flags: out_flags2, ovf: out_ovf2, nan: out_nan_seen2, count: {6'd0, out_count2}, sat: out_count_sat2};
        end
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int which, input logic [15:0] d, input logic s, input logic l);
        int n = 0;
        while (((which == 0) ? in_ready : in_ready2) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, want 1", n);
        end
        if (which == 0) begin
            in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
        end else begin
            in_valid2 = 1'b1; in_data2 = d; in_sub2 = s; in_last2 = l;
        end
        @(negedge clk);
        in_valid = 1'b0; in_valid2 = 1'b0;
    endtask

    task automatic wait_result(input int which, output res_t obs);
        int n = 0;
        while (((which == 0) ? out_valid : out_valid2) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL result_timeout: out_valid=0 after %0d cycles, want 1", n);
        end
        obs = snap(which);
        if (which == 0) out_ready = 1'b1; else out_ready2 = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        res_t obs;
        obs = snap(0);
        total++;
        if (obs !== RST_RES) begin bad++; $display("FAIL reset_outputs: got %h want %h", obs, RST_RES); end
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL reset_handshake: got %b want 10", {in_ready, out_valid}); end
        obs = snap(1);
        total++;
        if (obs !== RST_RES) begin bad++; $display("FAIL reset_outputs_w2: got %h want %h", obs, RST_RES); end
    endtask

    task automatic test_add();
        res_t obs, exp;
        send(0, 16'h3C00, 1'b0, 1'b0);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL add_busy: in_ready got %b want 0", in_ready); end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL add_rate: in_ready got %b want 1", in_ready); end
        sb.push_back('{data: 16'h4200, flags: 5'b00000, ovf: 1'b0, nan: 1'b0, count: 8'd2, sat: 1'b0});
        send(0, 16'h4000, 1'b0, 1'b1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL add_latency_early: out_valid got %b want 0", out_valid); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL add_latency: out_valid got %b want 1", out_valid); end
        wait_result(0, obs);
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL add_basic: got %h want %h", obs, exp); end
    endtask

    task automatic test_sub();
        res_t obs, exp;
        send(0, 16'h4200, 1'b0, 1'b0);
        sb.push_back('{data: 16'h4000, flags: 5'b00000, ovf: 1'b0, nan: 1'b0, count: 8'd2, sat: 1'b0});
        send(0, 16'h3C00, 1'b1, 1'b1);
        wait_result(0, obs);
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sub_basic: got %h want %h", obs, exp); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL back_to_back: in_ready got %b want 1", in_ready); end
        sb.push_back('{data: 16'hC000, flags: 5'b10000, ovf: 1'b0, nan: 1'b0, count: 8'd1, sat: 1'b0});
        send(0, 16'h4000, 1'b1, 1'b1);
        wait_result(0, obs);
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sub_negative: got %h want %h", obs, exp); end
    endtask

    task automatic test_overflow_hold();
        res_t obs, exp;
        int n = 0;
        send(0, 16'h7BFF, 1'b0, 1'b0);
        sb.push_back('{data: 16'h7C00, flags: 5'b00100, ovf: 1'b1, nan: 1'b0, count: 8'd2, sat: 1'b0});
        send(0, 16'h7BFF, 1'b0, 1'b1);
        while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        obs = snap(0);
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL ovf_result: got %h want %h", obs, exp); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_data, out_ovf} !== {1'b1, 1'b0, 16'h7C00, 1'b1}) begin
                bad++;
                $display("FAIL ovf_hold%0d: got v=%b r=%b d=%h o=%b want v=1 r=0 d=7c00 o=1", i, out_valid, in_ready, out_data, out_ovf);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        obs = snap(0);
        total++;
        if (obs !== RST_RES || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ovf_release: got %h r=%b v=%b want %h r=1 v=0", obs, in_ready, out_valid, RST_RES);
        end
    endtask

    task automatic test_special();
        res_t obs, exp;
        send(0, 16'h7C00, 1'b0, 1'b0);
        send(0, 16'h3C00, 1'b0, 1'b0);
        sb.push_back('{data: 16'h7FFF, flags: 5'b00010, ovf: 1'b0, nan: 1'b1, count: 8'd3, sat: 1'b0});
        send(0, 16'h7FFF, 1'b0, 1'b1);
        wait_result(0, obs);
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL nan_propagate: got %h want %h", obs, exp); end
        send(0, 16'h7C00, 1'b0, 1'b0);
        sb.push_back('{data: 16'h7FFF, flags: 5'b00010, ovf: 1'b0, nan: 1'b1, count: 8'd2, sat: 1'b0});
        send(0, 16'h7C00, 1'b1, 1'b1);
        wait_result(0, obs);
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL inf_minus_inf: got %h want %h", obs, exp); end
    endtask

    task automatic test_clear_reset();
        res_t obs, exp;
        send(0, 16'h3C00, 1'b0, 1'b0);
        send(0, 16'h4000, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h3C00; in_sub = 1'b0; in_last = 1'b1; clear = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        obs = snap(0);
        total++;
        if (obs !== RST_RES || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_drop: got %h r=%b want %h r=1", obs, in_ready, RST_RES);
        end
        sb.push_back('{data: 16'h4400, flags: 5'b00000, ovf: 1'b0, nan: 1'b0, count: 8'd1, sat: 1'b0});
        send(0, 16'h4400, 1'b0, 1'b1);
        wait_result(0, obs);
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL after_clear: got %h want %h", obs, exp); end
        send(0, 16'h3C00, 1'b0, 1'b0);
        send(0, 16'h4000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        obs = snap(0);
        total++;
        if (obs !== RST_RES || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got %h r=%b v=%b want %h r=1 v=0", obs, in_ready, out_valid, RST_RES);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_count_sat();
        res_t obs, exp;
        for (int i = 0; i < 4; i++) begin
            send(1, 16'h0000, 1'b0, 1'b0);
        end
        sb.push_back('{data: 16'h0000, flags: 5'b01000, ovf: 1'b0, nan: 1'b0, count: 8'd3, sat: 1'b1});
        send(1, 16'h0000, 1'b0, 1'b1);
        wait_result(1, obs);
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL count_sat: got %h want %h", obs, exp); end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        in_valid = 1'b0; in_data = 16'h0000; in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = 16'h0000; in_sub2 = 1'b0; in_last2 = 1'b0; out_ready2 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_overflow_hold();
        test_special();
        test_clear_reset();
        test_count_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
